// File: rtl/xnor_pattern_gen_if.sv
// Stimulus/response and status bundle between xnor_pattern_gen and its environment.
// The master side is the generator; the slave side is the XNOR stage plus the controller.
interface xnor_pattern_gen_if;
    logic       start;
    logic       stop;
    logic       dout0;
    logic       din0;
    logic       din1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_vec;
    logic [2:0] err_cnt;

    modport master (
        input  start, stop, dout0,
        output din0, din1, busy, done, pass, err_vec, err_cnt
    );

    modport slave (
        output start, stop, dout0,
        input  din0, din1, busy, done, pass, err_vec, err_cnt
    );
endinterface

// File: rtl/xnor_pattern_gen.sv
// Gray-order stimulus sequencer and response checker for a 2-input XNOR stage.
// Define XNOR_GEN_LOOP_EN for continuous back-to-back sequencing until stop.
module xnor_pattern_gen #(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    xnor_pattern_gen_if.master  bus
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

`ifdef XNOR_GEN_LOOP_EN
    localparam logic LOOP_EN = 1'b1;
`else
    localparam logic LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [1:0]    k_r, k_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [3:0]    run_r, run_nxt_s;
    logic [1:0]    din_r, din_nxt_s;
    logic          busy_r, busy_nxt_s;
    logic          done_r, done_nxt_s;
    logic          pass_r, pass_nxt_s;
    logic [3:0]    err_vec_r, err_vec_nxt_s;
    logic [2:0]    err_cnt_r, err_cnt_nxt_s;
    logic          mismatch_s;

    // {din0,din1} for pattern index k; one bit changes per step
    function automatic logic [1:0] pattern(input logic [1:0] k);
        case (k)
            2'd0:    pattern = 2'b00;
            2'd1:    pattern = 2'b01;
            2'd2:    pattern = 2'b11;
            2'd3:    pattern = 2'b10;
            default: pattern = 2'b00;
        endcase
    endfunction

    function automatic logic expected_resp(input logic [1:0] k);
        logic [1:0] p;
        p = pattern(k);
        expected_resp = ~(p[1] ^ p[0]);
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    assign mismatch_s = (bus.dout0 != expected_resp(k_r));

    // Next-state and next-output logic
    always_comb begin
        state_nxt_s   = state_r;
        k_nxt_s       = k_r;
        cnt_nxt_s     = cnt_r;
        run_nxt_s     = run_r;
        done_nxt_s    = 1'b0;
        pass_nxt_s    = pass_r;
        err_vec_nxt_s = err_vec_r;
        err_cnt_nxt_s = err_cnt_r;

        if (bus.stop) begin
            state_nxt_s = ST_IDLE;
            k_nxt_s     = 2'd0;
            cnt_nxt_s   = CW'(0);
            run_nxt_s   = 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_nxt_s = ST_DRIVE;
                        k_nxt_s     = 2'd0;
                        cnt_nxt_s   = CW'(0);
                        run_nxt_s   = 4'b0000;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s = CW'(0);
                        run_nxt_s = run_r | (mismatch_s ? (4'b0001 << k_r) : 4'b0000);
                        if (k_r == 2'd3) begin
                            // Status is loaded on entry so it is visible during DONE
                            state_nxt_s   = ST_DONE;
                            done_nxt_s    = 1'b1;
                            err_vec_nxt_s = run_nxt_s;
                            err_cnt_nxt_s = popcnt4(run_nxt_s);
                            pass_nxt_s    = (popcnt4(run_nxt_s) == 3'd0);
                        end else begin
                            k_nxt_s = k_r + 2'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    k_nxt_s   = 2'd0;
                    cnt_nxt_s = CW'(0);
                    run_nxt_s = 4'b0000;
                    if (LOOP_EN) begin
                        state_nxt_s = ST_DRIVE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    k_nxt_s     = 2'd0;
                    cnt_nxt_s   = CW'(0);
                    run_nxt_s   = 4'b0000;
                end
            endcase
        end

        if (state_nxt_s == ST_DRIVE) begin
            din_nxt_s = pattern(k_nxt_s);
        end else begin
            din_nxt_s = 2'b00;
        end

        if (state_nxt_s == ST_DRIVE) begin
            busy_nxt_s = 1'b1;
        end else if (state_nxt_s == ST_DONE) begin
            busy_nxt_s = LOOP_EN;
        end else begin
            busy_nxt_s = 1'b0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            k_r       <= 2'd0;
            cnt_r     <= CW'(0);
            run_r     <= 4'b0000;
            din_r     <= 2'b00;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_vec_r <= 4'b0000;
            err_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_nxt_s;
            k_r       <= k_nxt_s;
            cnt_r     <= cnt_nxt_s;
            run_r     <= run_nxt_s;
            din_r     <= din_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
            err_vec_r <= err_vec_nxt_s;
            err_cnt_r <= err_cnt_nxt_s;
        end
    end

    assign bus.din0    = din_r[1];
    assign bus.din1    = din_r[0];
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.pass    = pass_r;
    assign bus.err_vec = err_vec_r;
    assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_xnor_pattern_gen.sv
// Directed bench for xnor_pattern_gen with a behavioural XNOR stage and a result scoreboard.
module tb_xnor_pattern_gen;

`ifdef XNOR_GEN_LOOP_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 5;
`endif

    typedef struct packed {
        logic [3:0] ev;
        logic [2:0] ec;
        logic       ep;
    } exp_t;

    logic clk;
    logic rst_n;
    int   mode;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];

    xnor_pattern_gen_if bus ();

    xnor_pattern_gen #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stage under test: 0 = correct XNOR, 1 = XOR, 2 = stuck at 1
    assign bus.dout0 = (mode == 0) ? ~(bus.din0 ^ bus.din1) :
                       (mode == 1) ? (bus.din0 ^ bus.din1) : 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"}, {30'd0, bus.din0, bus.din1}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, bus.pass}, 32'd0);
        chk({tag, "_err_vec"}, {28'd0, bus.err_vec}, 32'd0);
        chk({tag, "_err_cnt"}, {29'd0, bus.err_cnt}, 32'd0);
    endtask

`ifndef XNOR_GEN_LOOP_EN
    // Full single-shot sequence: start, check stimulus each cycle, pop result on done
    task automatic run_seq(input int m, input logic [3:0] ev, input logic [2:0] ec, input logic ep);
        logic [1:0] pat [4];
        exp_t e;
        int   lat;
        bit   seen;
        pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b10;
        mode = m;
        @(negedge clk);
        bus.start = 1'b1;
        sb.push_back('{ev: ev, ec: ec, ep: ep});
        lat = 0;
        seen = 1'b0;
        for (int c = 1; c <= 4 * HOLD + 8 && !seen; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
                lat = c;
            end else if (c <= 4 * HOLD) begin
                chk($sformatf("din_c%0d", c), {30'd0, bus.din0, bus.din1}, {30'd0, pat[(c - 1) / HOLD]});
                chk("busy_drive", {31'd0, bus.busy}, 32'd1);
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("done_latency", lat, 4 * HOLD + 1);
        e = sb.pop_front();
        if (seen) begin
            chk("err_vec", {28'd0, bus.err_vec}, {28'd0, e.ev});
            chk("err_cnt", {29'd0, bus.err_cnt}, {29'd0, e.ec});
            chk("pass", {31'd0, bus.pass}, {31'd0, e.ep});
            chk("busy_done", {31'd0, bus.busy}, 32'd0);
            chk("din_done", {30'd0, bus.din0, bus.din1}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask
`endif

    initial begin
        int cyc;
        int ndone;
        n_assert = 0;
        n_fail = 0;
        mode = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        #2;
        chk_reset_vals("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef XNOR_GEN_LOOP_EN
        run_seq(0, 4'b0000, 3'd0, 1'b1);
        run_seq(1, 4'b1111, 3'd4, 1'b0);
        run_seq(2, 4'b1010, 3'd2, 1'b0);

        // Abort during the 8th DRIVE clock
        mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("stop_pre_din", {30'd0, bus.din0, bus.din1}, 32'd1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        chk("stop_din", {30'd0, bus.din0, bus.din1}, 32'd0);
        chk("stop_busy", {31'd0, bus.busy}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 4 * HOLD + 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("stop_no_done", ndone, 0);
        chk("stop_err_vec_kept", {28'd0, bus.err_vec}, 32'hA);
        chk("stop_err_cnt_kept", {29'd0, bus.err_cnt}, 32'd2);
        chk("stop_pass_kept", {31'd0, bus.pass}, 32'd0);
        run_seq(0, 4'b0000, 3'd0, 1'b1);

        // Reset in the middle of the k2 hold
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 2 * HOLD + 2; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk("rst_pre_din", {30'd0, bus.din0, bus.din1}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(1, 4'b1111, 3'd4, 1'b0);
`else
        // Continuous sequencing: a result per pass
        mode = 0;
        for (int p = 0; p < 3; p++) sb.push_back('{ev: 4'b0000, ec: 3'd0, ep: 1'b1});
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("loop_first_latency", cyc, 4 * HOLD + 1);
        for (int p = 0; p < 3; p++) begin
            exp_t e;
            e = sb.pop_front();
            chk("loop_err_vec", {28'd0, bus.err_vec}, {28'd0, e.ev});
            chk("loop_pass", {31'd0, bus.pass}, {31'd0, e.ep});
            chk("loop_busy_in_done", {31'd0, bus.busy}, 32'd1);
            if (p < 2) begin
                cyc = 0;
                do begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    bus.start = (p == 0 && cyc == 3);
                end while (!bus.done && cyc < 40);
                chk("loop_period", cyc, 4 * HOLD + 1);
            end
        end
        @(negedge clk);
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        chk("loop_stop_busy", {31'd0, bus.busy}, 32'd0);
        chk("loop_stop_din", {30'd0, bus.din0, bus.din1}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        chk("loop_stop_no_done", ndone, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
